// File: rtl/seg7_scroller_if.sv
// Register-side bundle for seg7_scroller: message/mode controls in, segment pins and
// window status out.
interface seg7_scroller_if #(
  parameter int NUM_DIGITS  = 8,
  parameter int MSG_NIBBLES = 16
);
  localparam int OW = (MSG_NIBBLES > 1) ? $clog2(MSG_NIBBLES) : 1;

  logic                      load;
  logic [4*MSG_NIBBLES-1:0]  msg;
  logic [1:0]                mode;
  logic                      pause;
  logic                      blank_lz;
  logic [7*NUM_DIGITS-1:0]   hex_out;
  logic [OW-1:0]             offset;
  logic                      tick;

  modport master (output load, msg, mode, pause, blank_lz,
                  input  hex_out, offset, tick);
  modport slave  (input  load, msg, mode, pause, blank_lz,
                  output hex_out, offset, tick);
endinterface

// File: rtl/seg7_scroller.sv
// Multi-digit active-low 7-segment driver showing a scrolling/blinking window of a
// latched hex message; segment outputs are registered.
module seg7_digit (
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'b1111111;
    if (!blank_i) begin
      case (nib_i)
        4'h0: seg_o = 7'b1000000;
        4'h1: seg_o = 7'b1111001;
        4'h2: seg_o = 7'b0100100;
        4'h3: seg_o = 7'b0110000;
        4'h4: seg_o = 7'b0011001;
        4'h5: seg_o = 7'b0010010;
        4'h6: seg_o = 7'b0000010;
        4'h7: seg_o = 7'b1111000;
        4'h8: seg_o = 7'b0000000;
        4'h9: seg_o = 7'b0010000;
        4'hA: seg_o = 7'b0001000;
        4'hB: seg_o = 7'b0000011;
        4'hC: seg_o = 7'b1000110;
        4'hD: seg_o = 7'b0100001;
        4'hE: seg_o = 7'b0000110;
        default: seg_o = 7'b0001110;
      endcase
    end
  end
endmodule

module seg7_scroller #(
  parameter int NUM_DIGITS  = 8,
  parameter int MSG_NIBBLES = 16,
  parameter int TICK_DIV    = 12500000
) (
  input logic            clk,
  input logic            rst_n,
  seg7_scroller_if.slave bus
);
  localparam int OW = (MSG_NIBBLES > 1) ? $clog2(MSG_NIBBLES) : 1;
  localparam int CW = $clog2(TICK_DIV);

  logic [MSG_NIBBLES-1:0][3:0] msg_q, msg_d;
  logic [OW-1:0]               off_q, off_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        phase_q, phase_d;
  logic [NUM_DIGITS-1:0][6:0]  hex_q, hex_d;

  logic                        tick_w;
  logic [NUM_DIGITS-1:0][OW-1:0] idx;
  logic [NUM_DIGITS-1:0][3:0]  nib;
  logic [NUM_DIGITS-1:0]       lzb, blank;
  logic                        lz_en, seen, blink_blank;

  // A load in the terminal-count cycle suppresses the tick, so it cannot step.
  assign tick_w = ~bus.load & ~bus.pause & (cnt_q == CW'(TICK_DIV-1));

  always_comb begin
    msg_d   = msg_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    phase_d = 1'b0;
    if (bus.load) begin
      msg_d = bus.msg;
      off_d = '0;
      cnt_d = '0;
    end else begin
      if (!bus.pause) cnt_d = tick_w ? '0 : cnt_q + 1'b1;
      if (tick_w) begin
        case (bus.mode)
          2'b01:   off_d = (off_q == OW'(MSG_NIBBLES-1)) ? '0 : off_q + 1'b1;
          2'b10:   off_d = (off_q == '0) ? OW'(MSG_NIBBLES-1) : off_q - 1'b1;
          default: off_d = off_q;
        endcase
      end
      if (bus.mode == 2'b11) phase_d = tick_w ? ~phase_q : phase_q;
    end
  end

  // Per-digit nibble select with explicit modular wrap (message length may be non-pow2).
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_lane
    logic [OW:0] sum;
    assign sum    = {1'b0, off_q} + (OW+1)'(d);
    assign idx[d] = (sum >= (OW+1)'(MSG_NIBBLES)) ? OW'(sum - (OW+1)'(MSG_NIBBLES))
                                                   : sum[OW-1:0];
    assign nib[d] = msg_q[idx[d]];
    seg7_digit u_dig (.nib_i(nib[d]), .blank_i(blank[d]), .seg_o(hex_d[d]));
  end

  always_comb begin
    lz_en = bus.blank_lz & ((bus.mode == 2'b00) | (bus.mode == 2'b11));
    seen  = 1'b0;
    lzb   = '0;
    for (int d = NUM_DIGITS-1; d >= 1; d--) begin
      seen   = seen | (nib[d] != 4'h0);
      lzb[d] = lz_en & ~seen;
    end
  end

  assign blink_blank = phase_q & (bus.mode == 2'b11);
  assign blank       = lzb | {NUM_DIGITS{blink_blank}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_q   <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      hex_q   <= '1;
    end else begin
      msg_q   <= msg_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hex_q   <= hex_d;
    end
  end

  assign bus.hex_out = hex_q;
  assign bus.offset  = off_q;
  assign bus.tick    = tick_w;
endmodule

// File: tb/tb_seg7_scroller.sv
// Scoreboard bench: two scrollers (8 digits/16 nibbles and 4 digits/10 nibbles) share
// stimulus; a spec-level model queues per-cycle expectations, a monitor compares.
module tb_seg7_scroller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [63:0] msg = '0;
  logic [1:0]  mode = 2'b00;
  logic        pause = 1'b0;
  logic        blank_lz = 1'b0;

  always #5 clk = ~clk;

  seg7_scroller_if #(.NUM_DIGITS(8), .MSG_NIBBLES(16)) if0 ();
  seg7_scroller_if #(.NUM_DIGITS(4), .MSG_NIBBLES(10)) if1 ();

  assign if0.load = load;  assign if0.msg = msg;        assign if0.mode = mode;
  assign if0.pause = pause; assign if0.blank_lz = blank_lz;
  assign if1.load = load;  assign if1.msg = msg[39:0];  assign if1.mode = mode;
  assign if1.pause = pause; assign if1.blank_lz = blank_lz;

  seg7_scroller #(.NUM_DIGITS(8), .MSG_NIBBLES(16), .TICK_DIV(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  seg7_scroller #(.NUM_DIGITS(4), .MSG_NIBBLES(10), .TICK_DIV(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  typedef struct packed {
    logic [55:0] hex;
    logic [3:0]  off;
    logic        tick;
  } exp_t;

  exp_t q0[$], q1[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_n  = 0;

  // Reference model state, one slot per DUT
  logic [63:0] mm[2];
  int          moff[2], mcnt[2];
  bit          mph[2];
  logic [55:0] mhex[2];

  function automatic logic [6:0] seg(logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001; 4'h2: return 7'b0100100;
      4'h3: return 7'b0110000; 4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000; 4'h8: return 7'b0000000;
      4'h9: return 7'b0010000; 4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001; 4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [55:0] disp(int k, logic [63:0] m, int off, bit ph,
                                       logic [1:0] md, bit lz);
    int N = (k != 0) ? 4 : 8;
    int M = (k != 0) ? 10 : 16;
    int hi = 0;
    logic [3:0]  nb[8];
    logic [55:0] r = '0;
    for (int d = 0; d < N; d++) begin
      nb[d] = m[4*((off + d) % M) +: 4];
      if (nb[d] != 4'h0) hi = d;
    end
    for (int d = 0; d < N; d++) begin
      if (md == 2'b11 && ph)                            r[7*d +: 7] = 7'h7F;
      else if (lz && (md == 2'b00 || md == 2'b11) && d > hi) r[7*d +: 7] = 7'h7F;
      else                                              r[7*d +: 7] = seg(nb[d]);
    end
    return r;
  endfunction

  // Queue what each DUT must show this cycle, then advance the model by one clock.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      int          M = (k != 0) ? 10 : 16;
      bit          t;
      logic [55:0] nh;
      logic [63:0] m;
      exp_t        e;
      if (!rst_n) begin
        mm[k] = '0; moff[k] = 0; mcnt[k] = 0; mph[k] = 1'b0;
        mhex[k] = (k != 0) ? {28'b0, {28{1'b1}}} : {56{1'b1}};
        e = '{hex: mhex[k], off: 4'd0, tick: 1'b0};
      end else begin
        t = !load && !pause && (mcnt[k] == 3);
        e = '{hex: mhex[k], off: moff[k][3:0], tick: t};
        nh = disp(k, mm[k], moff[k], mph[k], mode, blank_lz);
        if (load) begin
          m = msg;
          if (k != 0) m[63:40] = '0;
          mm[k] = m; moff[k] = 0; mcnt[k] = 0; mph[k] = 1'b0;
        end else begin
          if (!pause) mcnt[k] = (mcnt[k] + 1) % 4;
          if (t && mode == 2'b01) moff[k] = (moff[k] + 1) % M;
          if (t && mode == 2'b10) moff[k] = (moff[k] + M - 1) % M;
          mph[k] = (mode == 2'b11) ? (t ? !mph[k] : mph[k]) : 1'b0;
        end
        mhex[k] = nh;
      end
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic cyc(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cmp(int k, exp_t e, logic [55:0] hex, logic [3:0] off, logic tk);
    checks++;
    if (hex !== e.hex || off !== e.off || tk !== e.tick) begin
      errors++;
      $display("FAIL dut%0d cycle %0d: got hex=%h off=%0d tick=%b, expected hex=%h off=%0d tick=%b",
               k, cyc_n, hex, off, tk, e.hex, e.off, e.tick);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp(0, e, if0.hex_out, if0.offset, if0.tick);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp(1, e, {28'b0, if1.hex_out}, if1.offset, if1.tick);
    end
  end

  initial begin
    @(posedge clk); #1;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // static load
    msg = 64'h0123456789ABCDEF; mode = 2'b00; load = 1'b1; step(); load = 1'b0;
    cyc(6);

    // scroll left through a full wrap
    mode = 2'b01; cyc(70);

    // scroll right from offset 0
    load = 1'b1; step(); load = 1'b0;
    mode = 2'b10; cyc(12);

    // blink with leading-zero blanking
    msg = 64'h0000000000000A05; mode = 2'b11; blank_lz = 1'b1;
    load = 1'b1; step(); load = 1'b0;
    cyc(20);
    mode = 2'b00; cyc(3);
    blank_lz = 1'b0;

    // pause, then load collides with terminal count
    msg = 64'h0123456789ABCDEF; mode = 2'b01; cyc(5);
    pause = 1'b1; cyc(10); pause = 1'b0;
    for (int g = 0; g < 8 && mcnt[0] != 3; g++) step();
    load = 1'b1; step(); load = 1'b0;
    cyc(12);

    // mid-run reset
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(3);

    // randomized run
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
      pause = ($urandom_range(0, 7) == 0);
      load  = ($urandom_range(0, 29) == 0);
      if (load) msg = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                                  : 64'($urandom_range(0, 65535));
      step();
      load = 1'b0;
    end
    pause = 1'b0;
    cyc(2);

    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
